enc_btn_conditioner: RTL and testbench

- Front-end conditioner for the front-panel rotary encoder and push buttons. It synchronises and debounces the raw pins and decodes quadrature into detent steps.
- It drives the 5-bit input of the falling-edge-capturing button/encoder PIO.
- All outputs idle high. Every event appears as an active-low pulse, so the PIO's falling-edge detect captures exactly one edge per event.

---
 rtl/enc_btn_conditioner.sv | 204 ++++++++++++++++++++
 tb/tb_enc_btn_conditioner.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/enc_btn_conditioner.sv
// Front-panel encoder/button conditioner: sync, debounce, quadrature-to-detent decode,
// active-low step pulses. Define ENC_HALF_DETENT_EN for 2-detents-per-cycle encoders.
module enc_btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned PULSE_CYCLES    = 4,
    parameter int unsigned PEND_W          = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic [2:0] btn_n,
    output logic [4:0] btn_out,
    output logic       pend_ovf
);
    localparam int unsigned N_IN  = 5;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned TMR_W = (PULSE_CYCLES > 2) ? $clog2(PULSE_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

`ifdef ENC_HALF_DETENT_EN
    localparam logic signed [3:0] ACC_LIM = 4'sd2;
`else
    localparam logic signed [3:0] ACC_LIM = 4'sd4;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_GAP} pulse_st_e;

    logic [N_IN-1:0]  raw_c;
    logic [N_IN-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N_IN-1:0]  stable_q, stable_d;
    logic [CNT_W-1:0] db_cnt_q [N_IN];
    logic [CNT_W-1:0] db_cnt_d [N_IN];
    logic [2:0]       btn_q, btn_d;
    logic             ovf_q, ovf_d;

    logic [1:0]        ab_c, prev_q, prev_d, step_c;
    logic signed [3:0] acc_q, acc_d, acc_sum_c;
    logic              rest_c, cw_c, ccw_c, ovf_any_c;
    wire  [1:0]        step_evt_c;

    assign raw_c      = {btn_n, enc_b, enc_a};
    assign step_evt_c = {ccw_c, cw_c};

    // Two-flop synchronisers and per-input stable-count debouncers
    always_comb begin
        sync1_d  = raw_c;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        for (int i = 0; i < N_IN; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Gray {a,b} to position: 11->0, 10->1, 00->2, 01->3; position delta gives direction
    assign ab_c   = {stable_q[0], stable_q[1]};
    assign step_c = {~ab_c[1], ^ab_c} - {~prev_q[1], ^prev_q};

`ifdef ENC_HALF_DETENT_EN
    assign rest_c = (ab_c != prev_q) && ((ab_c == 2'b11) || (ab_c == 2'b00));
`else
    assign rest_c = (ab_c != prev_q) && (ab_c == 2'b11);
`endif

    // Saturating detent accumulator; evaluated and cleared on every rest-state entry
    always_comb begin
        prev_d    = ab_c;
        acc_sum_c = acc_q;
        cw_c      = 1'b0;
        ccw_c     = 1'b0;
        case (step_c)
            2'b01:   if (acc_q != ACC_LIM)  acc_sum_c = acc_q + 4'sd1;
            2'b11:   if (acc_q != -ACC_LIM) acc_sum_c = acc_q - 4'sd1;
            default: acc_sum_c = acc_q;
        endcase
        acc_d = acc_sum_c;
        if (rest_c) begin
            acc_d = '0;
            if (step_c != 2'b10) begin
                cw_c  = (acc_sum_c == ACC_LIM);
                ccw_c = (acc_sum_c == -ACC_LIM);
            end
        end
    end

    // One pulse generator per direction: bit 0 = CW, bit 1 = CCW
    for (genvar d = 0; d < 2; d++) begin : g_pulse
        pulse_st_e         state_q, state_d;
        logic [TMR_W-1:0]  timer_q, timer_d;
        logic [PEND_W-1:0] pend_q, pend_d;
        logic              out_q, out_d;
        logic              pend_nz_c, ovf_set_c;

        assign pend_nz_c = (pend_q != '0);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= ST_IDLE;
                timer_q <= '0;
                pend_q  <= '0;
                out_q   <= 1'b1;
            end else begin
                state_q <= state_d;
                timer_q <= timer_d;
                pend_q  <= pend_d;
                out_q   <= out_d;
            end
        end

        always_comb begin
            state_d = state_q;
            timer_d = timer_q;
            case (state_q)
                ST_IDLE: begin
                    if (step_evt_c[d] || pend_nz_c) begin
                        state_d = ST_LOW;
                        timer_d = TMR_LOAD;
                    end
                end
                ST_LOW: begin
                    if (timer_q == '0) begin
                        state_d = ST_GAP;
                        timer_d = TMR_LOAD;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                ST_GAP: begin
                    if (timer_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Pulse level and pending queue; a simultaneous event and service net to zero
        always_comb begin
            out_d     = (state_d != ST_LOW);
            pend_d    = pend_q;
            ovf_set_c = 1'b0;
            if (state_q == ST_IDLE) begin
                if (pend_nz_c && !step_evt_c[d]) begin
                    pend_d = pend_q - PEND_W'(1);
                end
            end else if (step_evt_c[d]) begin
                if (pend_q == PEND_MAX) begin
                    ovf_set_c = 1'b1;
                end else begin
                    pend_d = pend_q + PEND_W'(1);
                end
            end
        end
    end

    assign ovf_any_c = g_pulse[0].ovf_set_c | g_pulse[1].ovf_set_c;

    always_comb begin
        btn_d = stable_q[4:2];
        ovf_d = ovf_q | ovf_any_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            stable_q <= '1;
            for (int i = 0; i < N_IN; i++) begin
                db_cnt_q[i] <= '0;
            end
            prev_q   <= 2'b11;
            acc_q    <= '0;
            btn_q    <= '1;
            ovf_q    <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            for (int i = 0; i < N_IN; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            prev_q   <= prev_d;
            acc_q    <= acc_d;
            btn_q    <= btn_d;
            ovf_q    <= ovf_d;
        end
    end

    assign btn_out  = {btn_q, g_pulse[1].out_q, g_pulse[0].out_q};
    assign pend_ovf = ovf_q;

endmodule

// File: tb/tb_enc_btn_conditioner.sv
// Bench for enc_btn_conditioner: directed steps plus a random encoder walk scored
// against a detent-counting reference model.
module tb_enc_btn_conditioner;
    localparam int DB    = 8;
    localparam int PULSE = 4;
`ifdef ENC_HALF_DETENT_EN
    localparam int LIM  = 2;
    localparam bit HALF = 1'b1;
`else
    localparam int LIM  = 4;
    localparam bit HALF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enc_a, enc_b;
    logic [2:0] btn_n;
    wire  [4:0] btn_out;
    wire        pend_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    enc_btn_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .PULSE_CYCLES   (PULSE),
        .PEND_W         (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .btn_n   (btn_n),
        .btn_out (btn_out),
        .pend_ovf(pend_ovf)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse monitor: counts falling edges and checks low width / high gap
    int   falls [2]    = '{0, 0};
    int   low_len [2]  = '{0, 0};
    int   high_len [2] = '{1000, 1000};
    logic [1:0] lvl_prev = 2'b11;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                lvl_prev[d] = btn_out[d];
                low_len[d]  = 0;
                high_len[d] = 1000;
            end else if (lvl_prev[d] && !btn_out[d]) begin
                falls[d]++;
                if (high_len[d] < 1000)
                    check($sformatf("gap_width%0d", d), 32'(high_len[d] >= PULSE), 32'd1);
                low_len[d]  = 1;
                lvl_prev[d] = 1'b0;
            end else if (!btn_out[d]) begin
                low_len[d]++;
            end else if (!lvl_prev[d]) begin
                check($sformatf("low_width%0d", d), 32'(low_len[d]), 32'(PULSE));
                high_len[d] = 1;
                lvl_prev[d] = 1'b1;
            end else if (high_len[d] < 1000) begin
                high_len[d]++;
            end
        end
    end

    // Reference model: gray position walk, clamped detent sum, judged at rest states
    int pos = 0, acc = 0, exp_cw = 0, exp_ccw = 0;

    function automatic logic [1:0] gray(input int p);
        case (p)
            0:       return 2'b11;
            1:       return 2'b10;
            2:       return 2'b00;
            default: return 2'b01;
        endcase
    endfunction

    task automatic enc_step(input int dir, input int hold);
        pos = (pos + dir + 4) % 4;
        acc = acc + dir;
        if (acc > LIM)  acc = LIM;
        if (acc < -LIM) acc = -LIM;
        if (pos == 0 || (HALF && pos == 2)) begin
            if (acc == LIM)       exp_cw++;
            else if (acc == -LIM) exp_ccw++;
            acc = 0;
        end
        {enc_a, enc_b} = gray(pos);
        repeat (hold) @(negedge clk);
    endtask

    task automatic check_counts(input string tag);
        repeat (60) @(negedge clk);
        check({tag, "_cw"},  32'(falls[0]), 32'(exp_cw));
        check({tag, "_ccw"}, 32'(falls[1]), 32'(exp_ccw));
    endtask

    // Drive n consecutive CW event strobes straight into the pulse stage
    task automatic inject_cw(input int n);
        force dut.step_evt_c = 2'b01;
        repeat (n) @(negedge clk);
        release dut.step_evt_c;
    endtask

    logic seen_low;

    initial begin
        reset_n = 1'b0;
        enc_a   = 1'b1;
        enc_b   = 1'b1;
        btn_n   = 3'b111;
        repeat (3) @(negedge clk);
        check("reset_btn_out", 32'(btn_out), 32'h1F);
        check("reset_ovf", 32'(pend_ovf), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Reset in the middle of a CW low pulse with two steps queued
        inject_cw(3);
        exp_cw += 1;
        check("midlow_is_low", 32'(btn_out[0]), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_btn_out", 32'(btn_out), 32'h1F);
        check("async_reset_ovf", 32'(pend_ovf), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check_counts("no_resume");

        // Short glitch on btn_n[1] is filtered
        seen_low = 1'b0;
        btn_n[1] = 1'b0;
        repeat (5) @(negedge clk);
        btn_n[1] = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!btn_out[3]) seen_low = 1'b1;
        end
        check("glitch_filtered", 32'(seen_low), 32'd0);

        // Held press: output falls exactly DB+3 clocks after the raw edge
        btn_n[1] = 1'b0;
        for (int i = 1; i <= DB + 3; i++) begin
            @(posedge clk);
            #1;
            if (i == DB + 2) check("press_before", 32'(btn_out[3]), 32'd1);
            if (i == DB + 3) check("press_latency", 32'(btn_out[3]), 32'd0);
        end
        repeat (5) @(negedge clk);
        check("press_other_btns", 32'(btn_out[4:2]), 32'b101);
        btn_n[1] = 1'b1;
        repeat (DB + 6) @(negedge clk);
        check("release_btn", 32'(btn_out[4:2]), 32'b111);

        // One clean forward cycle
        for (int i = 0; i < 4; i++) enc_step(1, 20);
        check_counts("fwd_cycle");

        // Partial turn then reversed back to rest
        enc_step(1, 20);
        enc_step(1, 20);
        enc_step(-1, 20);
        enc_step(-1, 20);
        check_counts("partial_rev");

        // Three CW detents at 10 clocks per state
        for (int i = 0; i < 12; i++) enc_step(1, 10);
        check_counts("three_detents");

        // Short burst fits in the queue; long burst saturates it
        inject_cw(4);
        exp_cw += 4;
        check_counts("burst4");
        check("burst4_ovf", 32'(pend_ovf), 32'd0);
        inject_cw(9);
        exp_cw += 1 + 7;
        repeat (60) @(negedge clk);
        check_counts("burst9");
        check("burst9_ovf", 32'(pend_ovf), 32'd1);

        // Random walk on the encoder, mostly one direction per round
        for (int r = 0; r < 6; r++) begin
            int bias;
            bias = int'($urandom_range(0, 2));
            for (int s = 0; s < 24; s++) begin
                int dir;
                case (bias)
                    0:       dir = ($urandom_range(0, 9) < 8) ? 1 : -1;
                    1:       dir = ($urandom_range(0, 9) < 8) ? -1 : 1;
                    default: dir = ($urandom_range(0, 1) == 0) ? 1 : -1;
                endcase
                enc_step(dir, int'($urandom_range(10, 25)));
            end
            check_counts($sformatf("rand%0d", r));
        end
        check("final_ovf_sticky", 32'(pend_ovf), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
